// File: rtl/tensor_dot_sched.sv
// tensor_dot_sched: schedules one dot-product request at a time onto a LANES-wide FMA array.
// It splits len elements into ceil(len/LANES) issue beats and masks the partial tail beat.
// It waits for every FMA beat to complete, then starts and waits on the lane-reduction tree.
// Finally it holds the tagged result until the consumer takes it.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*   : request handshake (len, tag); req_ready high only when idle
//   fma_*   : issue beats (valid/ready, mask, first, last) and per-beat completion pulse fma_rsp
//   red_*   : reduction start handshake and one-cycle done pulse
//   rsp_*   : result handshake, tag, and empty flag for len==0 requests
//   busy    : not idle;  err : sticky protocol error (stray fma_rsp or red_done)
module tensor_dot_sched #(
  parameter int unsigned LANES = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fma_valid,
  input  logic             fma_ready,
  output logic [LANES-1:0] fma_mask,
  output logic             fma_first,
  output logic             fma_last,
  input  logic             fma_rsp,
  output logic             red_valid,
  input  logic             red_ready,
  input  logic             red_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_empty,
  output logic             busy,
  output logic             err
);

  localparam int unsigned LaneBits = $clog2(LANES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_REDUCE   = 3'd3;
  localparam logic [2:0] S_WAIT_RED = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  logic [2:0]          r_state, w_state_d;
  logic [LEN_W-1:0]    r_beats, r_beat;
  logic [LEN_W:0]      r_out, w_out_d;
  logic [LaneBits-1:0] r_rem;
  logic [TAG_W-1:0]    r_tag;
  logic                r_empty, r_err;

  logic                w_fire, w_rsp_ok, w_rsp_bad, w_last_beat, w_accept;
  logic [LEN_W:0]      w_beats_calc;
  logic [LANES-1:0]    w_beat_mask;

  // Extra MSB keeps the round-up add from overflowing for len near the field maximum.
  assign w_beats_calc = ({1'b0, req_len} + (LEN_W + 1)'(LANES - 1)) >> LaneBits;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_fire      = fma_valid && fma_ready;
  assign w_last_beat = (r_beat == r_beats - 1'b1);
  // A completion with nothing outstanding is a protocol error and must not underflow.
  assign w_rsp_ok    = fma_rsp && (r_out != '0);
  assign w_rsp_bad   = fma_rsp && (r_out == '0);

  always_comb begin
    w_out_d = r_out;
    if (w_fire && !w_rsp_ok) begin
      w_out_d = r_out + 1'b1;
    end else if (!w_fire && w_rsp_ok) begin
      w_out_d = r_out - 1'b1;
    end
  end

  // Tail beat enables only the low (len mod LANES) lanes; a zero remainder means a full beat.
  always_comb begin
    w_beat_mask = '1;
    if (w_last_beat && (r_rem != '0)) begin
      for (int i = 0; i < LANES; i++) begin
        w_beat_mask[i] = (i < int'(r_rem));
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:     if (req_valid) w_state_d = (req_len != '0) ? S_ISSUE : S_RESP;
      S_ISSUE:    if (w_fire && w_last_beat) w_state_d = S_DRAIN;
      S_DRAIN:    if (w_out_d == '0) w_state_d = S_REDUCE;
      S_REDUCE:   if (red_ready) w_state_d = S_WAIT_RED;
      S_WAIT_RED: if (red_done) w_state_d = S_RESP;
      S_RESP:     if (rsp_ready) w_state_d = S_IDLE;
      default:    w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_beats <= '0;
      r_beat  <= '0;
      r_out   <= '0;
      r_rem   <= '0;
      r_tag   <= '0;
      r_empty <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      if (w_fire) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_rsp_bad || (red_done && (r_state != S_WAIT_RED))) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_tag   <= req_tag;
        r_rem   <= req_len[LaneBits-1:0];
        r_beats <= w_beats_calc[LEN_W-1:0];
        r_beat  <= '0;
        r_out   <= '0;
        r_empty <= (req_len == '0);
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign fma_valid = (r_state == S_ISSUE);
  assign fma_mask  = fma_valid ? w_beat_mask : '0;
  assign fma_first = fma_valid && (r_beat == '0);
  assign fma_last  = fma_valid && w_last_beat;
  assign red_valid = (r_state == S_REDUCE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_tag   = rsp_valid ? r_tag : '0;
  assign rsp_empty = rsp_valid && r_empty;
  assign err       = r_err;

endmodule

// File: tb/tb_tensor_dot_sched.sv
module tb_tensor_dot_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_len;
  logic [3:0] req_tag;
  logic       fma_valid;
  logic       fma_ready;
  logic [3:0] fma_mask;
  logic       fma_first;
  logic       fma_last;
  logic       fma_rsp;
  logic       red_valid;
  logic       red_ready;
  logic       red_done;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_tag;
  logic       rsp_empty;
  logic       busy;
  logic       err;

  logic auto_en, auto_rsp, man_rsp, d0, d1;
  int   rsp_cnt;
  int   n_chk = 0;
  int   n_fail = 0;

  assign fma_rsp = auto_rsp | man_rsp;

  always #5 clk = ~clk;

  tensor_dot_sched #(.LANES(4), .LEN_W(8), .TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .req_tag   (req_tag),
    .fma_valid (fma_valid),
    .fma_ready (fma_ready),
    .fma_mask  (fma_mask),
    .fma_first (fma_first),
    .fma_last  (fma_last),
    .fma_rsp   (fma_rsp),
    .red_valid (red_valid),
    .red_ready (red_ready),
    .red_done  (red_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_empty (rsp_empty),
    .busy      (busy),
    .err       (err)
  );

  // FMA array model: one completion pulse captured two rising edges after each fired beat.
  initial begin
    d0 = 1'b0;
    d1 = 1'b0;
    auto_rsp = 1'b0;
    rsp_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      auto_rsp = auto_en & d1;
      if (auto_rsp) rsp_cnt++;
      d1 = d0;
      d0 = auto_en & fma_valid & fma_ready & reset;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         len;
    int         tag;
    int         stall;
    int         beats;
    logic [3:0] last_mask;
    logic       empty;
  } vec_t;

  // Full request through the whole flow with the auto responder and always-ready sinks.
  task automatic run_req(input vec_t v);
    int   idx, base, cyc;
    logic done, red_pend;
    logic [3:0] exp_mask;
    @(negedge clk);
    req_valid = 1'b1;
    req_len   = 8'(v.len);
    req_tag   = 4'(v.tag);
    fma_ready = (v.stall == 0);
    #1 check("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    base = rsp_cnt;
    idx = 0;
    cyc = 0;
    done = 1'b0;
    red_pend = 1'b0;
    while (!done && cyc < 400) begin
      fma_ready = (cyc >= v.stall);
      red_done  = red_pend;
      red_pend  = 1'b0;
      #1;
      if (fma_valid) begin
        exp_mask = (idx == v.beats - 1) ? v.last_mask : 4'hF;
        check("beat_mask", 32'(fma_mask), 32'(exp_mask));
        check("beat_first", 32'(fma_first), 32'(idx == 0));
        check("beat_last", 32'(fma_last), 32'(idx == v.beats - 1));
        if (fma_ready) idx++;
      end
      if (red_valid) begin
        check("red_after_all_rsp", 32'(rsp_cnt - base), 32'(v.beats));
        red_pend = 1'b1;
      end
      if (rsp_valid) begin
        check("rsp_tag", 32'(rsp_tag), 32'(v.tag));
        check("rsp_empty", 32'(rsp_empty), 32'(v.empty));
        check("beat_count", 32'(idx), 32'(v.beats));
        done = 1'b1;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    check("req_timeout", 32'(done), 32'd1);
    red_done = 1'b0;
    @(negedge clk);
    #1;
    check("back_idle_ready", 32'(req_ready), 32'd1);
    check("back_idle_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{len: 10,  tag: 3,  stall: 0, beats: 3,  last_mask: 4'b0011, empty: 1'b0};
    vecs[1] = '{len: 0,   tag: 5,  stall: 0, beats: 0,  last_mask: 4'b0000, empty: 1'b1};
    vecs[2] = '{len: 4,   tag: 7,  stall: 3, beats: 1,  last_mask: 4'b1111, empty: 1'b0};
    vecs[3] = '{len: 1,   tag: 1,  stall: 0, beats: 1,  last_mask: 4'b0001, empty: 1'b0};
    vecs[4] = '{len: 7,   tag: 2,  stall: 2, beats: 2,  last_mask: 4'b0111, empty: 1'b0};
    vecs[5] = '{len: 8,   tag: 9,  stall: 0, beats: 2,  last_mask: 4'b1111, empty: 1'b0};
    vecs[6] = '{len: 255, tag: 15, stall: 0, beats: 64, last_mask: 4'b0111, empty: 1'b0};
    vecs[7] = '{len: 5,   tag: 0,  stall: 1, beats: 2,  last_mask: 4'b0001, empty: 1'b0};

    reset = 1'b0;
    req_valid = 1'b0;
    req_len = '0;
    req_tag = '0;
    fma_ready = 1'b1;
    red_ready = 1'b1;
    red_done = 1'b0;
    rsp_ready = 1'b1;
    man_rsp = 1'b0;
    auto_en = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fma_valid", 32'(fma_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_req(vecs[i]);
    check("err_after_table", 32'(err), 32'd0);

    // Completion coincident with the final beat firing leaves one beat outstanding.
    auto_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_len = 8'd8;
    req_tag = 4'hC;
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("co_first", 32'(fma_first), 32'd1);
    @(negedge clk);
    #1 check("co_last", 32'(fma_last), 32'd1);
    man_rsp = 1'b1;
    @(negedge clk);
    man_rsp = 1'b0;
    #1 check("co_drain_fma", 32'(fma_valid), 32'd0);
    check("co_drain_red0", 32'(red_valid), 32'd0);
    @(negedge clk);
    man_rsp = 1'b1;
    #1 check("co_drain_red1", 32'(red_valid), 32'd0);
    @(negedge clk);
    man_rsp = 1'b0;
    #1 check("co_red_valid", 32'(red_valid), 32'd1);
    check("co_err", 32'(err), 32'd0);
    @(negedge clk);
    red_done = 1'b1;
    @(negedge clk);
    red_done = 1'b0;
    #1 check("co_rsp_valid", 32'(rsp_valid), 32'd1);
    check("co_rsp_tag", 32'(rsp_tag), 32'hC);
    @(negedge clk);
    #1 check("co_idle", 32'(busy), 32'd0);
    auto_en = 1'b1;

    // Consumer back-pressure, no accept on the RESP exit cycle, then stray fma_rsp.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_len = 8'd0;
    req_tag = 4'hA;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_tag", 32'(rsp_tag), 32'hA);
      check("bp_rsp_empty", 32'(rsp_empty), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("bp_no_accept", 32'(busy), 32'd0);
    check("bp_err_clear", 32'(err), 32'd0);
    @(negedge clk);
    man_rsp = 1'b1;
    @(negedge clk);
    man_rsp = 1'b0;
    #1 check("stray_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("stray_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of ISSUE abandons the request.
    @(negedge clk);
    fma_ready = 1'b0;
    req_valid = 1'b1;
    req_len = 8'd8;
    req_tag = 4'h6;
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("mid_issue", 32'(fma_valid), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mr_fma_valid", 32'(fma_valid), 32'd0);
    check("mr_req_ready", 32'(req_ready), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    fma_ready = 1'b1;
    #1 check("mr_no_rsp", 32'(rsp_valid), 32'd0);
    run_req('{len: 8, tag: 4, stall: 0, beats: 2, last_mask: 4'b1111, empty: 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_dot_sched.md
TENSOR_DOT_SCHED -- requirements
Module: tensor_dot_sched

Interface
REQ-001 SHALL have parameter LANES, default 4: FMA lanes per issue beat; power of two, at least 2.
REQ-002 SHALL have parameter LEN_W, default 8: width of element-count field.
REQ-003 SHALL have parameter TAG_W, default 4: request tag width.
REQ-004 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: dot-product request offered.
REQ-007 SHALL have port req_ready, output, 1: request accepted when both high.
REQ-008 SHALL have port req_len, input, LEN_W: element count, 0 legal.
REQ-009 SHALL have port req_tag, input, TAG_W: request tag.
REQ-010 SHALL have port fma_valid, output, 1: issue beat to FMA array.
REQ-011 SHALL have port fma_ready, input, 1: FMA array accepts beat.
REQ-012 SHALL have port fma_mask, output, LANES: active-lane mask of current beat.
REQ-013 SHALL have port fma_first, output, 1: beat 0; FMA clears accumulators.
REQ-014 SHALL have port fma_last, output, 1: final beat of request.
REQ-015 SHALL have port fma_rsp, input, 1: one pulse per completed FMA beat.
REQ-016 SHALL have port red_valid, output, 1: start lane-reduction tree.
REQ-017 SHALL have port red_ready, input, 1: reduction accepts start.
REQ-018 SHALL have port red_done, input, 1: reduction result ready, one-cycle pulse.
REQ-019 SHALL have port rsp_valid, output, 1: result available.
REQ-020 SHALL have port rsp_ready, input, 1: consumer takes result.
REQ-021 SHALL have port rsp_tag, output, TAG_W: tag of finished request.
REQ-022 SHALL have port rsp_empty, output, 1: request had req_len 0; result is +0.0.
REQ-023 SHALL have port busy, output, 1: state not IDLE.
REQ-024 SHALL have port err, output, 1: sticky protocol error.

Function
REQ-025 SHALL implement states IDLE, ISSUE, DRAIN, REDUCE, WAIT_RED, RESP.
REQ-026 SHALL drive req_ready high only in IDLE (combinational from state).
REQ-027 SHALL on IDLE accept: latch tag and len, compute beats = ceil(len/LANES), zero beat and outstanding counters; go ISSUE if len>0, else RESP with rsp_empty=1.
REQ-028 SHALL in ISSUE hold fma_valid high; beat counter increments only when fma_valid and fma_ready both high.
REQ-029 SHALL assert fma_first with beat index 0 and fma_last with beat index beats-1; both may be high together.
REQ-030 SHALL drive fma_mask all-ones except on last beat: low (len mod LANES) bits set when the remainder is nonzero.
REQ-031 SHALL leave ISSUE for DRAIN the cycle after the last beat fires.
REQ-032 SHALL keep outstanding counter: +1 on beat fire, -1 on fma_rsp, unchanged when both occur in one cycle; counter width LEN_W+1.
REQ-033 SHALL in DRAIN move to REDUCE once outstanding is 0, including the same cycle's fma_rsp.
REQ-034 SHALL in REDUCE hold red_valid until red_ready, then WAIT_RED.
REQ-035 SHALL in WAIT_RED move to RESP on red_done.
REQ-036 SHALL in RESP hold rsp_valid, rsp_tag, rsp_empty stable until rsp_ready, then IDLE; no new request accepted that cycle.
REQ-037 SHALL set err on fma_rsp with outstanding 0 (counter not decremented) or on red_done outside WAIT_RED; err clears only on reset.
REQ-038 SHALL hold all control outputs low in states where they are not asserted.

Reset
REQ-039 SHALL on reset low asynchronously enter IDLE, zero counters, latched tag/len, err; all outputs low except req_ready high.
REQ-040 SHALL abandon any in-flight request on reset with no response generated.

Verification
REQ-041 LANES=4, len=10, tag=3, fma_ready=1, fma_rsp 2 cycles after each beat -> 3 beats, masks 1111,1111,0011, first on beat 0, last on beat 2; red_valid after 3rd rsp; rsp_tag=3 after red_done.
REQ-042 len=0, tag=5 -> no fma_valid/red_valid; rsp_valid next cycle with rsp_empty=1, rsp_tag=5.
REQ-043 len=4 with fma_ready low 3 cycles -> fma_valid, mask 1111, first=last=1 held stable until ready; single beat.
REQ-044 fma_rsp coincident with beat fire -> outstanding unchanged; DRAIN exit exact on final rsp.
REQ-045 rsp_ready low 5 cycles -> rsp fields stable, req_ready low; fma_rsp injected in IDLE -> err=1 and stays 1.
REQ-046 reset asserted mid-ISSUE -> outputs to reset values immediately; next request of len 8 completes normally.
